// File: rtl/fft_frame_ctrl_if.sv
// Stream bundle between the FIR output, the frame sequencer and the FFT input.
// The master side is the environment (FIR source and FFT sink); the slave side is the sequencer.
interface fft_frame_ctrl_if #(
  parameter int DW = 16
);
  logic          fir_valid;
  logic [DW-1:0] fir_d;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_d;
  logic          out_last;
  logic [7:0]    frame_cnt;
  logic          overflow;
  logic          clr_ovf;

  modport master (
    output fir_valid, fir_d, out_ready, clr_ovf,
    input  out_valid, out_d, out_last, frame_cnt, overflow
  );

  modport slave (
    input  fir_valid, fir_d, out_ready, clr_ovf,
    output out_valid, out_d, out_last, frame_cnt, overflow
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Ping-pong frame buffer: collects FIR samples into FRAME_LEN-sample frames and
// streams each completed frame to the FFT over valid/ready, flagging dropped samples.
module fft_frame_ctrl #(
  parameter int FRAME_LEN = 16,
  parameter int DW        = 16
) (
  input logic             CLK,
  input logic             RST,
  fft_frame_ctrl_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] bank_q [2][FRAME_LEN];
  logic [DW-1:0] bank_d [2][FRAME_LEN];
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic          rd_bank_q, rd_bank_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          overflow_q, overflow_d;

  logic xfer;
  logic free_now;
  logic wr_accept;
  logic wr_reject;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      frame_cnt_q <= 8'd0;
      overflow_q  <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < FRAME_LEN; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overflow_q  <= overflow_d;
      bank_q      <= bank_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overflow_d  = overflow_q;
    bank_d      = bank_q;

    xfer     = (state_q == STREAM) && bus.out_ready;
    free_now = xfer && (rd_cnt_q == LAST_IDX);

    // Reader: the clear of full for the drained bank is applied before the writer's set.
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d  = STREAM;
          rd_cnt_d = '0;
        end
      end
      STREAM: begin
        if (xfer) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (free_now) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            rd_cnt_d          = '0;
            frame_cnt_d       = frame_cnt_q + 8'd1;
            state_d           = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A full bank may be refilled in the cycle its last sample leaves.
    wr_accept = bus.fir_valid &&
                (!full_q[wr_bank_q] || (free_now && (rd_bank_q == wr_bank_q)));
    wr_reject = bus.fir_valid && !wr_accept;

    if (wr_accept) begin
      bank_d[wr_bank_q][wr_cnt_q] = bus.fir_d;
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
      end else begin
        wr_cnt_d = wr_cnt_q + CW'(1);
      end
    end

    if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
    if (wr_reject) begin
      overflow_d = 1'b1;
    end
  end

  assign bus.out_valid = (state_q == STREAM);
  assign bus.out_last  = (state_q == STREAM) && (rd_cnt_q == LAST_IDX);
  assign bus.out_d     = (state_q == STREAM) ? bank_q[rd_bank_q][rd_cnt_q] : '0;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.overflow  = overflow_q;

endmodule
